// File: rtl/output_bank_cntl_pkg.sv
// output_bank_cntl_pkg: shared widths, queue depth and the bank-to-edge-PE lane struct.
package output_bank_cntl_pkg;
  localparam int FV_DATA_W = 64;
  localparam int ADDR_W = 8;
  localparam int PE_TAG_W = 2;
  localparam int LEN_W = 4;
  localparam int REQ_FIFO_DEPTH = 4;
  localparam int Num_Edge_PE = 4;
  localparam int Num_Banks_FV = 4;
  typedef struct packed {
    logic                 valid;
    logic                 sos;
    logic                 eos;
    logic [PE_TAG_W-1:0]  PE_tag;
    logic [FV_DATA_W-1:0] FV_data;
  } FV_bank_CNTL2Edge_PE;
  typedef struct packed {
    logic [PE_TAG_W-1:0] tag;
    logic [ADDR_W-1:0]   addr;
    logic [LEN_W-1:0]    len;
  } req_t;
endpackage

// File: rtl/output_req_fifo.sv
// output_req_fifo: small synchronous request queue with full/empty flags.
module output_req_fifo import output_bank_cntl_pkg::*; (
  input  logic clk,
  input  logic reset,
  input  logic i_push,
  input  req_t i_wdata,
  input  logic i_pop,
  output req_t o_rdata,
  output logic o_full,
  output logic o_empty
);
  localparam int PW = $clog2(REQ_FIFO_DEPTH);
  req_t r_mem [REQ_FIFO_DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [PW:0] r_cnt;
  logic w_push, w_pop;
  assign o_full = r_cnt == (PW+1)'(REQ_FIFO_DEPTH);
  assign o_empty = r_cnt == '0;
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rp];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_wdata;
  end
endmodule

// File: rtl/output_bank_cntl.sv
// output_bank_cntl: queues burst read requests for one FV bank and streams the
// words, tagged with sos/eos and destination PE, onto one output lane.
module output_bank_cntl import output_bank_cntl_pkg::*; (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [PE_TAG_W-1:0]  req_PE_tag,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [LEN_W-1:0]     req_len,
  output logic                 sram_cen,
  output logic [ADDR_W-1:0]    sram_addr,
  input  logic [FV_DATA_W-1:0] sram_rdata,
  output FV_bank_CNTL2Edge_PE  out,
  output logic                 busy
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] READ = 1'b1;
  logic [0:0] r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0] r_cnt;
  logic [PE_TAG_W-1:0] r_tag, r_ptag;
  logic r_first, r_pv, r_psos, r_peos;
  FV_bank_CNTL2Edge_PE r_out;
  req_t w_head;
  logic w_full, w_empty, w_last, w_pop;
  output_req_fifo u_fifo (
    .clk(clk),
    .reset(reset),
    .i_push(req_valid),
    .i_wdata('{tag: req_PE_tag, addr: req_addr, len: req_len}),
    .i_pop(w_pop),
    .o_rdata(w_head),
    .o_full(w_full),
    .o_empty(w_empty)
  );
  assign w_last = r_state == READ && r_cnt == '0;
  // Loading on the last word of a burst keeps READ running without a bubble.
  assign w_pop = !w_empty && (r_state == IDLE || w_last);
  assign req_ready = !w_full;
  assign sram_cen = r_state == READ;
  assign sram_addr = r_addr;
  assign out = r_out;
  assign busy = !w_empty || r_state == READ || r_pv;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_addr <= '0;
      r_cnt <= '0;
      r_tag <= '0;
      r_first <= 1'b0;
      r_pv <= 1'b0;
      r_psos <= 1'b0;
      r_peos <= 1'b0;
      r_ptag <= '0;
      r_out <= '0;
    end else begin
      r_pv <= sram_cen;
      r_psos <= sram_cen && r_first;
      r_peos <= w_last;
      r_ptag <= sram_cen ? r_tag : '0;
      r_out <= r_pv ? '{valid: 1'b1, sos: r_psos, eos: r_peos, PE_tag: r_ptag, FV_data: sram_rdata} : '0;
      if (w_pop) begin
        r_state <= READ;
        r_addr <= w_head.addr;
        r_cnt <= w_head.len;
        r_tag <= w_head.tag;
        r_first <= 1'b1;
      end else if (sram_cen) begin
        r_addr <= r_addr + 1'b1;
        r_cnt <= r_cnt - 1'b1;
        r_first <= 1'b0;
        if (w_last) r_state <= IDLE;
      end
    end
  end
endmodule

// File: doc/output_bank_cntl.md
OUTPUT_BANK_CNTL -- requirements
Module: output_bank_cntl

Interface
REQ-001 Params (from shared package): FV_DATA_W=64 (feature-vector word width); ADDR_W=8 (bank address width, 256 words); PE_TAG_W=2 (log2 of Num_Edge_PE=4); LEN_W=4 (burst length field); REQ_FIFO_DEPTH=4 (request queue entries).
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 req_valid  in  1  read request present.
REQ-005 req_ready  out  1  request queue can accept this cycle.
REQ-006 req_PE_tag  in  PE_TAG_W  destination edge PE.
REQ-007 req_addr  in  ADDR_W  first bank word address.
REQ-008 req_len  in  LEN_W  burst length minus one (1..16 words).
REQ-009 sram_cen  out  1  active-high bank read enable.
REQ-010 sram_addr  out  ADDR_W  bank read address.
REQ-011 sram_rdata  in  FV_DATA_W  bank read data, valid the cycle after sram_cen.
REQ-012 out  out  FV_bank_CNTL2Edge_PE struct {valid, sos, eos, PE_tag, FV_data}; feeds one lane of the output bus.
REQ-013 busy  out  1  high when queue non-empty, FSM not IDLE, or read pipeline holds a word.

Function
REQ-014 Request accepted on a cycle with req_valid and req_ready both high; the request is pushed into the queue.
REQ-015 req_ready SHALL equal queue-not-full; it does not depend on a same-cycle pop.
REQ-016 FSM states: IDLE, READ.
REQ-017 IDLE with queue non-empty: pop the head, load cur_addr, remaining count = req_len, and cur_tag; go to READ.
REQ-018 READ: each cycle assert sram_cen with sram_addr=cur_addr, increment cur_addr modulo 256, decrement count.
REQ-019 Issuing the word with count==0: if the queue is non-empty, pop and load the next burst so READ continues with no bubble; otherwise go to IDLE.
REQ-020 A one-stage tag pipeline carries {sos, eos, PE_tag} alongside each read; sos marks the first word of a burst, eos the last; a single-word burst sets both.
REQ-021 out is registered: a read issued in cycle t appears on out in cycle t+2 with FV_data=sram_rdata; out.valid is low in every other cycle, and all fields are zero when out.valid is low.
REQ-022 Latency: request accepted in cycle a into an empty, idle block -> first sram_cen in cycle a+2 -> first out.valid in cycle a+4.
REQ-023 Throughput: one word per cycle sustained across back-to-back bursts.
REQ-024 Address wrap: 0xFF is followed by 0x00 within a burst, with no error.
REQ-025 No backpressure on out; the downstream lane always accepts.

Reset
REQ-026 Reset asserted SHALL immediately apply: FSM=IDLE, queue empty, pipeline valid cleared, sram_cen=0, sram_addr=0, out all-zero, busy=0, and req_ready=1 after deassertion.
REQ-027 Reset mid-burst SHALL discard the burst and queued requests; no eos is emitted for the aborted burst.

Structure
REQ-028 Package holds FV_DATA_W, ADDR_W, PE_TAG_W, LEN_W, REQ_FIFO_DEPTH, Num_Edge_PE, Num_Banks_FV, and the FV_bank_CNTL2Edge_PE typedef shared with the output bus.
REQ-029 The request queue is a sub-module output_req_fifo: synchronous, depth REQ_FIFO_DEPTH, with full/empty flags and the same asynchronous reset.
REQ-030 One output_bank_cntl instance is built per FV bank.

Verification
REQ-031 Request tag=2, addr=0x10, len=3, with SRAM word n = n -> out words 0x10..0x13 in cycles a+4..a+7; sos on 0x10, eos on 0x13, PE_tag=2.
REQ-032 Requests (tag0, 0x00, len0) and (tag1, 0x40, len1) back-to-back -> out valid for 3 consecutive cycles; the first word has sos and eos set; 0x40 carries sos and 0x41 carries eos with tag1.
REQ-033 Five requests pushed with no drain -> req_ready low after the fourth push; the fifth is held until a pop; all five bursts emerge in order.
REQ-034 Request addr=0xFE, len=2 -> sram_addr sequence 0xFE, 0xFF, 0x00.
REQ-035 Reset asserted during the second word of a len=7 burst -> out zero in the same cycle, busy=0, and no further valid or eos until a new request.
REQ-036 Idle with no requests for 20 cycles -> sram_cen=0 and out.valid=0 throughout.
